sa_axis_host_master: RTL and testbench

- Host-side stream engine for the output-stationary systolic-array accelerator.
- Holds one A tile (row_len x k_len) and one B tile (k_len x col_len) in local buffers.
- Transmits A then B as two tlast-terminated AXIS packets, then collects the row_len x col_len C result packet into a result buffer.
- Sits between the control CPU/testbench side and the accelerator's AXIS input/output ports.

---
 rtl/sa_axis_host_master.sv | 195 +++++++++++++++++++
 tb/tb_sa_axis_host_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_axis_host_master.sv
// Host-side stream engine: sends the A tile then the B tile as AXIS packets and
// collects the C result packet. Define RESULT_TIMEOUT_EN for the RECV_C watchdog.
module sa_axis_host_master #(
   parameter int DW      = 8,
   parameter int OW      = 16,
   parameter int P       = 8,
   parameter int Q       = 8,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 1024,
   parameter int AW      = $clog2(P*Q)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    row_len,
   input  logic [7:0]    col_len,
   input  logic [7:0]    k_len,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic          len_err,
   input  logic          buf_we,
   input  logic          buf_sel,
   input  logic [AW-1:0] buf_addr,
   input  logic [DW-1:0] buf_wdata,
   input  logic [AW-1:0] res_raddr,
   output logic [OW-1:0] res_rdata,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   input  logic [OW-1:0] s_axis_tdata,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
`ifdef RESULT_TIMEOUT_EN
   output logic          timeout_err,
`endif
   input  logic          s_axis_tlast
);
   localparam int         DEPTH = P*Q;
   localparam logic [7:0] P8    = 8'(P);
   localparam logic [7:0] Q8    = 8'(Q);

   typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_GAP, S_SEND_B, S_RECV_C, S_DONE} state_t;
   state_t state, state_nx;

   logic [DW-1:0] a_mem   [DEPTH];
   logic [DW-1:0] b_mem   [DEPTH];
   logic [OW-1:0] res_mem [DEPTH];

   logic [7:0]    row_l, col_l, k_l, pr, pc, nx_r, nx_c, sw;
   logic [15:0]   cnt, cnt_inc, a_tot, b_tot, c_tot;
   logic [3:0]    gap_cnt;
   logic          cfg_ok, start_ok, m_xfer, s_xfer, m_end, c_end, gap_end, wd_fire;
   logic [AW-1:0] nx_addr, wr_addr;
   logic [DW-1:0] a0;

   assign cfg_ok   = (row_len != 8'd0) && (col_len != 8'd0) && (k_len != 8'd0) &&
                     (row_len <= P8) && (col_len <= Q8) && (k_len <= Q8) && (k_len <= P8);
   assign start_ok = start && (state == S_IDLE) && cfg_ok;
   assign m_xfer   = m_axis_tvalid && m_axis_tready;
   assign s_xfer   = s_axis_tvalid && s_axis_tready;
   assign m_end    = m_xfer && m_axis_tlast;
   assign cnt_inc  = cnt + 16'd1;
   assign c_end    = s_xfer && (s_axis_tlast || (cnt_inc == c_tot));
   assign gap_end  = (gap_cnt == 4'(GAP-1));
   assign a_tot    = 16'(row_l) * 16'(k_l);
   assign b_tot    = 16'(k_l) * 16'(col_l);
   assign c_tot    = 16'(row_l) * 16'(col_l);

   // Element walker shared by A send (width k), B send and C receive (width col).
   assign sw = (state == S_SEND_A) ? k_l : col_l;
   always_comb begin
      nx_c = pc + 8'd1;
      nx_r = pr;
      if (nx_c == sw) begin
         nx_c = '0;
         nx_r = pr + 8'd1;
      end
   end
   assign nx_addr = AW'(int'(nx_r) * Q + int'(nx_c));
   assign wr_addr = AW'(int'(pr) * Q + int'(pc));

   // A write landing in the start cycle must reach the first A beat.
   assign a0 = (buf_we && !buf_sel && (buf_addr == '0)) ? buf_wdata : a_mem[0];

`ifdef RESULT_TIMEOUT_EN
   logic [31:0] wd;
   assign wd_fire = (state == S_RECV_C) && !s_xfer && (wd == 32'(TIMEOUT-1));
   always_ff @(posedge clk) begin
      if (rst) begin
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (start_ok)     timeout_err <= 1'b0;
         else if (wd_fire) timeout_err <= 1'b1;
         if (state != S_RECV_C || s_xfer) wd <= '0;
         else                             wd <= wd + 32'd1;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start_ok)         state_nx = S_SEND_A;
         S_SEND_A: if (m_end)            state_nx = S_GAP;
         S_GAP:    if (gap_end)          state_nx = S_SEND_B;
         S_SEND_B: if (m_end)            state_nx = S_RECV_C;
         S_RECV_C: if (c_end || wd_fire) state_nx = S_DONE;
         S_DONE:                         state_nx = S_IDLE;
         default:                        state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state == S_SEND_A) || (state == S_GAP) ||
                      (state == S_SEND_B) || (state == S_RECV_C);
      done          = (state == S_DONE);
      m_axis_tvalid = (state == S_SEND_A) || (state == S_SEND_B);
      s_axis_tready = (state == S_RECV_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_l <= '0; col_l <= '0; k_l <= '0;
         cnt <= '0; pr <= '0; pc <= '0; gap_cnt <= '0;
         m_axis_tdata <= '0; m_axis_tlast <= 1'b0;
         cfg_err <= 1'b0; len_err <= 1'b0;
      end else begin
         cfg_err <= start && (state == S_IDLE) && !cfg_ok;
         case (state)
            S_IDLE: if (start_ok) begin
               row_l <= row_len; col_l <= col_len; k_l <= k_len;
               len_err      <= 1'b0;
               cnt          <= '0; pr <= '0; pc <= '0;
               m_axis_tdata <= a0;
               m_axis_tlast <= (row_len == 8'd1) && (k_len == 8'd1);
            end
            S_SEND_A: if (m_xfer) begin
               if (m_axis_tlast) gap_cnt <= '0;
               else begin
                  cnt <= cnt_inc; pr <= nx_r; pc <= nx_c;
                  m_axis_tdata <= a_mem[nx_addr];
                  m_axis_tlast <= (cnt_inc == a_tot - 16'd1);
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt + 4'd1;
               if (gap_end) begin
                  cnt <= '0; pr <= '0; pc <= '0;
                  m_axis_tdata <= b_mem[0];
                  m_axis_tlast <= (k_l == 8'd1) && (col_l == 8'd1);
               end
            end
            S_SEND_B: if (m_xfer) begin
               if (m_axis_tlast) begin
                  cnt <= '0; pr <= '0; pc <= '0;
               end else begin
                  cnt <= cnt_inc; pr <= nx_r; pc <= nx_c;
                  m_axis_tdata <= b_mem[nx_addr];
                  m_axis_tlast <= (cnt_inc == b_tot - 16'd1);
               end
            end
            S_RECV_C: if (s_xfer) begin
               cnt <= cnt_inc; pr <= nx_r; pc <= nx_c;
               // tlast at exactly beat E is the only clean ending.
               if (c_end) len_err <= s_axis_tlast ? (cnt_inc != c_tot) : 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && buf_we && int'(buf_addr) < DEPTH) begin
         if (buf_sel) b_mem[buf_addr] <= buf_wdata;
         else         a_mem[buf_addr] <= buf_wdata;
      end
      if (state == S_RECV_C && s_xfer) res_mem[wr_addr] <= s_axis_tdata;
   end

   always_ff @(posedge clk) begin
      if (rst)                            res_rdata <= '0;
      else if (int'(res_raddr) < DEPTH)   res_rdata <= res_mem[res_raddr];
      else                                res_rdata <= '0;
   end
endmodule

// File: tb/tb_sa_axis_host_master.sv
// Scoreboard bench for sa_axis_host_master: expected A/B beats are queued from a
// matrix model and popped by a stream monitor; results come from plain matmul.
module tb_sa_axis_host_master;
   localparam int P = 8, Q = 8, GAP = 2, DW = 8, OW = 16, AW = 6;

   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] row_len = '0, col_len = '0, k_len = '0;
   logic start = 1'b0;
   logic busy, done, cfg_err, len_err;
   logic buf_we = 1'b0, buf_sel = 1'b0;
   logic [AW-1:0] buf_addr = '0, res_raddr = '0;
   logic [DW-1:0] buf_wdata = '0;
   logic [OW-1:0] res_rdata;
   logic [DW-1:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
   logic [OW-1:0] s_axis_tdata = '0;
   logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;

   sa_axis_host_master dut (
      .clk(clk), .rst(rst), .row_len(row_len), .col_len(col_len), .k_len(k_len),
      .start(start), .busy(busy), .done(done), .cfg_err(cfg_err), .len_err(len_err),
      .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .res_raddr(res_raddr), .res_rdata(res_rdata),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast));

   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; logic l; bit is_a; } beat_t;
   beat_t exp_q[$];
   beat_t bq;
   logic [7:0]  am [64];
   logic [7:0]  bm [64];
   logic [15:0] rm [64];
   bit          rk [64];
   int n_cmp = 0, n_bad = 0, done_cnt = 0, rdy_pct = 100, gap_n = 0;
   bit b_seen = 0, in_gap = 0, stall = 0;
   logic [7:0] st_d;
   logic st_l;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
   end

   // Stream monitor: pops the scoreboard on every transfer, checks stalls and the A/B gap.
   always @(negedge clk) begin
      if (rst) begin
         in_gap = 0; stall = 0;
      end else begin
         if (done) begin done_cnt++; chk("done_busy_low", busy, 0); end
         if (stall) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, st_d);
            chk("stall_last", m_axis_tlast, st_l);
         end
         if (in_gap && m_axis_tvalid) begin
            chk("gap_len", gap_n, GAP); in_gap = 0; b_seen = 1;
         end else if (in_gap) gap_n++;
         stall = m_axis_tvalid && !m_axis_tready;
         st_d = m_axis_tdata; st_l = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            chk("m_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               bq = exp_q.pop_front();
               chk("m_data", m_axis_tdata, bq.d);
               chk("m_last", m_axis_tlast, bq.l);
               if (bq.is_a && bq.l) begin in_gap = 1; gap_n = 0; end
            end
         end
      end
   end

   task automatic wr(input bit sel, input int addr, input logic [7:0] d);
      @(posedge clk); #1;
      buf_we = 1; buf_sel = sel; buf_addr = AW'(addr); buf_wdata = d;
      @(posedge clk); #1;
      buf_we = 0;
      if (sel) bm[addr] = d; else am[addr] = d;
   endtask

   task automatic push_exp(input int r, input int c, input int k);
      beat_t bt;
      for (int i = 0; i < r; i++)
         for (int j = 0; j < k; j++) begin
            bt.d = am[i*Q+j]; bt.l = (i == r-1) && (j == k-1); bt.is_a = 1;
            exp_q.push_back(bt);
         end
      for (int i = 0; i < k; i++)
         for (int j = 0; j < c; j++) begin
            bt.d = bm[i*Q+j]; bt.l = (i == k-1) && (j == c-1); bt.is_a = 0;
            exp_q.push_back(bt);
         end
   endtask

   task automatic do_start(input int r, input int c, input int k, input bit coinc, input logic [7:0] cd);
      @(posedge clk); #1;
      start = 1; row_len = 8'(r); col_len = 8'(c); k_len = 8'(k);
      if (coinc) begin buf_we = 1; buf_sel = 0; buf_addr = '0; buf_wdata = cd; end
      @(posedge clk); #1;
      start = 0; buf_we = 0;
   endtask

   task automatic run_op(input int r, input int c, input int k, input int early,
                         input bit no_last, input bit coinc, input logic [7:0] cd);
      logic [15:0] cm [64];
      logic [15:0] acc;
      int e, nb, to;
      if (coinc) am[0] = cd;
      push_exp(r, c, k);
      for (int i = 0; i < r; i++)
         for (int j = 0; j < c; j++) begin
            acc = '0;
            for (int kk = 0; kk < k; kk++) acc += 16'(am[i*Q+kk]) * 16'(bm[kk*Q+j]);
            cm[i*c+j] = acc;
         end
      done_cnt = 0; b_seen = 0;
      do_start(r, c, k, coinc, cd);
      // write while busy must be ignored; B[0] is read only after the gap
      buf_we = 1; buf_sel = 1; buf_addr = '0; buf_wdata = ~bm[0];
      @(negedge clk); chk("busy_run", busy, 1);
      @(posedge clk); #1; buf_we = 0;
      to = 0;
      while (!s_axis_tready && to < 5000) begin @(posedge clk); #1; to++; end
      chk("recv_reached", s_axis_tready, 1);
      e = r * c; nb = (early > 0) ? early : e;
      for (int n = 0; n < nb; n++) begin
         s_axis_tvalid = 1; s_axis_tdata = cm[n]; s_axis_tlast = !no_last && (n == nb-1);
         rm[(n/c)*Q + n%c] = cm[n]; rk[(n/c)*Q + n%c] = 1;
         @(posedge clk); #1;
      end
      s_axis_tvalid = 0; s_axis_tlast = 0;
      to = 0;
      while (busy && to < 50) begin @(posedge clk); #1; to++; end
      repeat (2) @(posedge clk);
      #1;
      chk("busy_end", busy, 0);
      chk("done_once", done_cnt, 1);
      chk("len_err", len_err, no_last || (early > 0 && early < e));
      chk("all_beats_sent", exp_q.size(), 0);
      for (int idx = 0; idx < 64; idx++)
         if (rk[idx]) begin
            res_raddr = AW'(idx);
            @(posedge clk); #1;
            chk($sformatf("res[%0d]", idx), res_rdata, rm[idx]);
         end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0); chk({tag, "_len_err"}, len_err, 0);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0); chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_tlast"}, m_axis_tlast, 0);   chk({tag, "_tready"}, s_axis_tready, 0);
      chk({tag, "_rdata"}, res_rdata, 0);
   endtask

   task automatic cfg_bad(input int r, input int c, input int k);
      do_start(r, c, k, 0, 8'h0);
      @(negedge clk);
      chk("cfg_err_pulse", cfg_err, 1); chk("cfg_busy", busy, 0); chk("cfg_tvalid", m_axis_tvalid, 0);
      @(negedge clk);
      chk("cfg_err_clear", cfg_err, 0); chk("cfg_busy2", busy, 0); chk("cfg_tvalid2", m_axis_tvalid, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r, c, k, to;
      repeat (3) @(posedge clk);
      @(negedge clk); chk_zero("reset");
      @(posedge clk); #1; rst = 0;

      // 2x3x2 directed case; A[0] arrives with the start pulse
      wr(0, 0, 8'd99); wr(0, 1, 8'd2); wr(0, 2, 8'd3);
      wr(0, 8, 8'd4);  wr(0, 9, 8'd5); wr(0, 10, 8'd6);
      wr(1, 0, 8'd1);  wr(1, 1, 8'd0); wr(1, 8, 8'd0);
      wr(1, 9, 8'd1);  wr(1, 16, 8'd1); wr(1, 17, 8'd1);
      run_op(2, 2, 3, 0, 0, 1, 8'd1);
      chk("c00", rm[0], 4); chk("c01", rm[1], 5); chk("c10", rm[8], 10); chk("c11", rm[9], 11);

      // full 8x8x8 under random backpressure
      for (int a = 0; a < 64; a++) begin
         wr(0, a, 8'($urandom)); wr(1, a, 8'($urandom));
      end
      rdy_pct = 50;
      run_op(8, 8, 8, 0, 0, 0, 8'h0);

      rdy_pct = 100;
      run_op(2, 2, 2, 2, 0, 0, 8'h0);

      cfg_bad(2, 2, 9); cfg_bad(0, 2, 2); cfg_bad(2, 9, 2); cfg_bad(9, 2, 2);
      chk("len_err_sticky", len_err, 1);

      // abort mid-SEND_B, then replay
      push_exp(4, 4, 4);
      done_cnt = 0; b_seen = 0;
      do_start(4, 4, 4, 0, 8'h0);
      to = 0;
      while (!b_seen && to < 300) begin @(posedge clk); #1; to++; end
      chk("b_started", b_seen, 1);
      rst = 1;
      @(posedge clk); #1; rst = 0; exp_q.delete();
      @(negedge clk); chk_zero("abort");
      chk("no_done_abort", done_cnt, 0);
      run_op(4, 4, 4, 0, 0, 0, 8'h0);

      rdy_pct = 70;
      for (int t = 0; t < 4; t++) begin
         r = $urandom_range(1, 8); c = $urandom_range(1, 8); k = $urandom_range(1, 8);
         for (int w = 0; w < 6; w++) wr($urandom_range(0, 1), $urandom_range(0, 63), 8'($urandom));
         run_op(r, c, k, 0, (t == 2), 0, 8'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
